// File: rtl/mpsoc_wb_burst_master.sv
// rtl/mpsoc_wb_burst_master.sv - Wishbone registered-feedback burst master with command, write and read streams
module mpsoc_wb_burst_master #(
    parameter int           AW      = 32,
    parameter int           DW      = 32,
    parameter logic [7:0]   TIMEOUT = 8'd255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [AW-1:0]       cmd_adr,
    input  logic                cmd_we,
    input  logic [3:0]          cmd_len,
    input  logic [1:0]          cmd_bte,
    input  logic [DW-1:0]       wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DW-1:0]       rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                done_err,
    output logic [4:0]          done_beats,
    output logic [AW-1:0]       wb_adr_o,
    output logic [DW-1:0]       wb_dat_o,
    output logic [DW/8-1:0]     wb_sel_o,
    output logic                wb_we_o,
    output logic [1:0]          wb_bte_o,
    output logic [2:0]          wb_cti_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    input  logic                wb_rty_i,
    input  logic [DW-1:0]       wb_dat_i
);

    localparam int SEL = DW / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_WAITW = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [3:0]    len_q;
    logic [4:0]    acks;
    logic [4:0]    fetched;
    logic          full;
    logic [7:0]    tmo;

    logic          live;
    logic          term_err;
    logic          beat_ack;
    logic          last_ack;
    logic          tmo_hit;
    logic          abort;
    logic          fetch;
    logic [AW-1:0] step;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] nxt_adr;

    // Burst-type encoding for a given beat index: classic for single beats, end-of-burst on the last
    function automatic logic [2:0] cti_for(input logic [4:0] idx, input logic [3:0] len);
        if (len == 4'd0)
            cti_for = 3'b000;
        else if (idx == {1'b0, len})
            cti_for = 3'b111;
        else
            cti_for = 3'b010;
    endfunction

    assign wb_sel_o = {SEL{1'b1}};

    // Termination decode, beat-register refill and next burst address
    always_comb begin
        live      = wb_cyc_o & wb_stb_o;
        term_err  = wb_err_i | wb_rty_i;
        beat_ack  = live & wb_ack_i & ~term_err;
        last_ack  = beat_ack & (acks == {1'b0, len_q});
        tmo_hit   = live & ~wb_ack_i & ~term_err & (tmo == TIMEOUT - 8'd1);
        abort     = live & (term_err | tmo_hit);
        wr_ready  = ((state == S_BUS) || (state == S_WAITW)) & wb_we_o
                    & (~full | beat_ack) & (fetched <= {1'b0, len_q});
        fetch     = wr_valid & wr_ready;
        step      = AW'(SEL);
        case (wb_bte_o)
            2'b01:   wrap_mask = AW'(15);
            2'b10:   wrap_mask = AW'(31);
            2'b11:   wrap_mask = AW'(63);
            default: wrap_mask = '1;
        endcase
        nxt_adr   = (wb_adr_o & ~wrap_mask) | ((wb_adr_o + step) & wrap_mask);
    end

    // Burst sequencer: command latch, beat issue, terminations and completion reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            len_q      <= 4'd0;
            acks       <= 5'd0;
            fetched    <= 5'd0;
            full       <= 1'b0;
            tmo        <= 8'd0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            done       <= 1'b0;
            done_err   <= 1'b0;
            done_beats <= 5'd0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_bte_o   <= 2'b00;
            wb_cti_o   <= 3'b000;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_adr;
                        wb_we_o   <= cmd_we;
                        wb_bte_o  <= cmd_bte;
                        wb_cti_o  <= cti_for(5'd0, cmd_len);
                        len_q     <= cmd_len;
                        acks      <= 5'd0;
                        fetched   <= 5'd0;
                        full      <= 1'b0;
                        tmo       <= 8'd0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= ~cmd_we;
                        cmd_ready <= 1'b0;
                        state     <= S_BUS;
                    end
                end
                S_BUS, S_WAITW: begin
                    if (fetch) begin
                        wb_dat_o <= wr_data;
                        fetched  <= fetched + 5'd1;
                    end
                    if (abort) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        full       <= 1'b0;
                        done       <= 1'b1;
                        done_err   <= 1'b1;
                        done_beats <= acks;
                        state      <= S_DONE;
                    end else if (beat_ack) begin
                        acks     <= acks + 5'd1;
                        wb_adr_o <= nxt_adr;
                        tmo      <= 8'd0;
                        if (!wb_we_o) begin
                            rd_valid <= 1'b1;
                            rd_data  <= wb_dat_i;
                        end
                        if (last_ack) begin
                            wb_cyc_o   <= 1'b0;
                            wb_stb_o   <= 1'b0;
                            full       <= 1'b0;
                            done       <= 1'b1;
                            done_err   <= 1'b0;
                            done_beats <= acks + 5'd1;
                            state      <= S_DONE;
                        end else begin
                            wb_cti_o <= cti_for(acks + 5'd1, len_q);
                            if (wb_we_o) begin
                                full     <= fetch;
                                wb_stb_o <= fetch;
                                state    <= fetch ? S_BUS : S_WAITW;
                            end
                        end
                    end else if (live) begin
                        tmo <= tmo + 8'd1;
                    end else if (wb_we_o && !full) begin
                        tmo <= 8'd0;
                        if (fetch) begin
                            full     <= 1'b1;
                            wb_stb_o <= 1'b1;
                            state    <= S_BUS;
                        end else begin
                            state    <= S_WAITW;
                        end
                    end
                end
                default: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
